// File: rtl/data_mem_bytelane.sv
`timescale 1ns/1ps
// Word-organised data memory with byte/half/word access, load extension,
// sticky alignment/range fault capture and a post-reset clearing sweep.
module data_mem_bytelane #(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        WE,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        busy,
  output logic        fault,
  output logic [31:0] fault_addr,
  input  logic        fault_clr,
  output logic [31:0] test_value
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t        r_state;
  logic [AW-1:0] r_idx;
  logic          r_busy;
  logic          r_fault;
  logic [31:0]   r_fault_addr;
  logic [31:0]   r_mem [DEPTH];

  logic [AW-1:0] w_idx;
  logic          w_oor;
  logic          w_bad_align;
  logic          w_fault;
  logic          w_ok;
  logic          w_store;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_ext;

  assign w_idx = A[AW+1:2];

  always_comb begin
    w_oor       = (A >> (AW + 2)) != 32'd0;
    w_bad_align = 1'b0;
    unique case (size)
      2'b00:   w_bad_align = 1'b0;
      2'b01:   w_bad_align = A[0];
      2'b10:   w_bad_align = (A[1:0] != 2'b00);
      default: w_bad_align = 1'b1;
    endcase
    w_fault = en & ~r_busy & (w_oor | w_bad_align);
    w_ok    = en & ~r_busy & ~(w_oor | w_bad_align);
    w_store = w_ok & WE;
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = WD;
    unique case (size)
      2'b00: begin
        w_be    = 4'b0001 << A[1:0];
        w_wdata = {4{WD[7:0]}};
      end
      2'b01: begin
        w_be    = A[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{WD[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = WD;
      end
    endcase
  end

  always_comb begin
    w_word = r_mem[w_idx];
    w_byte = w_word[{A[1:0], 3'b000} +: 8];
    w_half = A[1] ? w_word[31:16] : w_word[15:0];
    w_ext  = w_word;
    unique case (size)
      2'b00:   w_ext = {{24{sign_ext & w_byte[7]}}, w_byte};
      2'b01:   w_ext = {{16{sign_ext & w_half[15]}}, w_half};
      default: w_ext = w_word;
    endcase
  end

  // RD reflects pre-edge contents even in a store cycle, so a same-cycle store
  // shows the old word until the following cycle.
  assign RD         = w_ok ? w_ext : '0;
  assign busy       = r_busy;
  assign fault      = r_fault;
  assign fault_addr = r_fault_addr;
  assign test_value = r_busy ? '0 : r_mem[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_INIT;
      r_idx   <= '0;
      r_busy  <= 1'b1;
    end else begin
      unique case (r_state)
        S_INIT: begin
          r_idx <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            r_state <= S_RUN;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_INIT) begin
      r_mem[r_idx] <= '0;
    end else if (w_store) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  // A new fault outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
    end else if (w_fault && (!r_fault || fault_clr)) begin
      r_fault      <= 1'b1;
      r_fault_addr <= A;
    end else if (fault_clr) begin
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
    end
  end

endmodule

// File: tb/tb_data_mem_bytelane.sv
`timescale 1ns/1ps
// Directed bench for data_mem_bytelane: init sweep, lane access, extension,
// fault capture/clear priority and same-cycle store/load ordering.
module tb_data_mem_bytelane;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        WE = 1'b0;
  logic [1:0]  size = 2'b10;
  logic        sign_ext = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] WD = '0;
  logic [31:0] RD;
  logic        busy;
  logic        fault;
  logic [31:0] fault_addr;
  logic        fault_clr = 1'b0;
  logic [31:0] test_value;

  int n_tests = 0;
  int n_fail  = 0;

  data_mem_bytelane #(.DEPTH(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .WE         (WE),
    .size       (size),
    .sign_ext   (sign_ext),
    .A          (A),
    .WD         (WD),
    .RD         (RD),
    .busy       (busy),
    .fault      (fault),
    .fault_addr (fault_addr),
    .fault_clr  (fault_clr),
    .test_value (test_value)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b0; WE = 1'b0; fault_clr = 1'b0;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] sz);
    en = 1'b1; WE = 1'b1; A = addr; WD = data; size = sz;
    tick();
    idle();
  endtask

  task automatic load(input logic [31:0] addr, input logic [1:0] sz, input logic se,
                      output logic [31:0] rd);
    en = 1'b1; WE = 1'b0; A = addr; size = sz; sign_ext = se;
    #1;
    rd = RD;
    tick();
    idle();
  endtask

  // Counts edges until busy drops; also flags any non-zero RD/test_value seen while busy.
  task automatic count_sweep(output int edges, output logic leak);
    edges = 0;
    leak  = 1'b0;
    while (busy && edges < 400) begin
      if (RD !== 32'd0 || test_value !== 32'd0) leak = 1'b1;
      tick();
      edges++;
    end
  endtask

  initial begin
    logic [31:0] rd;
    int          edges;
    logic        leak;

    tick();
    tick();
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_fault_addr", fault_addr, 32'd0);

    // Release away from the edge, then attempt a store during the sweep.
    @(negedge clk);
    rst = 1'b1;
    en = 1'b1; WE = 1'b1; A = 32'h0; WD = 32'hDEADBEEF; size = 2'b10;
    #1;
    count_sweep(edges, leak);
    idle();
    check("sweep_edges", edges, 32'd256);
    check("sweep_quiet", {31'd0, leak}, 32'd0);
    check("busy_store_ignored", test_value, 32'd0);
    check("busy_no_fault", {31'd0, fault}, 32'd0);

    store(32'h10, 32'h12345678, 2'b10);
    load(32'h11, 2'b00, 1'b1, rd); check("lb_11", rd, 32'h00000056);
    load(32'h12, 2'b01, 1'b1, rd); check("lh_12", rd, 32'h00001234);
    load(32'h10, 2'b10, 1'b1, rd); check("lw_10", rd, 32'h12345678);

    store(32'h13, 32'h000000FF, 2'b00);
    load(32'h13, 2'b00, 1'b1, rd); check("lb_13_sx", rd, 32'hFFFFFFFF);
    load(32'h13, 2'b00, 1'b0, rd); check("lb_13_zx", rd, 32'h000000FF);
    load(32'h12, 2'b01, 1'b1, rd); check("lh_12_sx", rd, 32'hFFFFFF34);
    load(32'h12, 2'b01, 1'b0, rd); check("lh_12_zx", rd, 32'h0000FF34);
    load(32'h10, 2'b10, 1'b0, rd); check("lw_10_merged", rd, 32'hFF345678);
    check("no_fault_yet", {31'd0, fault}, 32'd0);

    // Misaligned half store: suppressed and captured.
    store(32'h21, 32'h0000BEEF, 2'b01);
    check("sh21_fault", {31'd0, fault}, 32'd1);
    check("sh21_addr", fault_addr, 32'h21);
    load(32'h20, 2'b10, 1'b0, rd); check("w20_unchanged", rd, 32'h0);

    // Out-of-range word: RD blanked, first fault address retained.
    en = 1'b1; WE = 1'b0; A = 32'h400; size = 2'b10;
    #1;
    check("oor_rd_zero", RD, 32'h0);
    tick();
    idle();
    store(32'h400, 32'hCAFEF00D, 2'b10);
    check("oor_keeps_addr", fault_addr, 32'h21);
    check("oor_fault_set", {31'd0, fault}, 32'd1);

    fault_clr = 1'b1;
    tick();
    idle();
    check("clr_fault", {31'd0, fault}, 32'd0);
    check("clr_addr", fault_addr, 32'd0);

    // Illegal size with a simultaneous clear: the new fault wins.
    fault_clr = 1'b1; en = 1'b1; WE = 1'b0; A = 32'h8; size = 2'b11;
    #1;
    check("illegal_rd_zero", RD, 32'h0);
    tick();
    idle();
    check("clr_vs_fault", {31'd0, fault}, 32'd1);
    check("clr_vs_fault_addr", fault_addr, 32'h8);

    store(32'h0, 32'hA5A5A5A5, 2'b10);
    check("test_value_a5", test_value, 32'hA5A5A5A5);

    // Same-cycle store and load: old word this cycle, new word next.
    en = 1'b1; WE = 1'b1; A = 32'h30; WD = 32'h11111111; size = 2'b10;
    #1;
    check("same_cycle_old", RD, 32'h0);
    tick();
    WE = 1'b0;
    #1;
    check("next_cycle_new", RD, 32'h11111111);
    tick();
    idle();

    // Second sweep interrupted at index 100.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    count_sweep(edges, leak);
    check("partial_sweep", edges, 32'd256);
    // count_sweep ran the whole thing; redo with an abort to exercise restart.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (100) tick();
    check("busy_at_100", {31'd0, busy}, 32'd1);
    check("tv_at_100", test_value, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    count_sweep(edges, leak);
    check("restart_edges", edges, 32'd256);
    check("restart_quiet", {31'd0, leak}, 32'd0);
    check("restart_tv", test_value, 32'd0);
    check("restart_fault", {31'd0, fault}, 32'd0);
    load(32'h10, 2'b10, 1'b0, rd); check("restart_cleared", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_bytelane.md
Name: data_mem_bytelane

Overview:
- Parametrised successor to the single-cycle MIPS data memory.
- Word-organised RAM with byte, halfword and word loads/stores, selectable sign or zero extension on loads, and alignment/range fault capture.
- After reset, a sequential init sweep clears the array one word per cycle, replacing a single-cycle bulk clear.
- Reads are combinational and writes are synchronous, so it drops into the single-cycle datapath. `busy` gates the core during the sweep.

Parameters:
- DEPTH, 256, number of 32-bit words; must be a power of 2, ≥ 4.
- AW, $clog2(DEPTH), word-index width; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- en  in  1  access valid this cycle
- WE  in  1  store when 1, load when 0; qualified by en
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- sign_ext  in  1  1 = sign-extend byte/half loads, 0 = zero-extend
- A  in  32  byte address
- WD  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- RD  out  32  load data, extended; combinational
- busy  out  1  init sweep in progress
- fault  out  1  sticky access fault flag
- fault_addr  out  32  A of the first faulting access since last clear
- fault_clr  in  1  synchronous clear of fault and fault_addr
- test_value  out  32  mem[0], for bench observation

Behaviour:
- Reset (rst=0, async): state=INIT, sweep index=0, busy=1, fault=0, fault_addr=0. The array is not reset directly.
- INIT state: each posedge writes 0 to mem[index] and increments index. On the edge that clears mem[DEPTH-1], go to RUN and set busy=0. busy is high for exactly DEPTH rising edges after rst deasserts.
- While busy=1: stores are ignored, fault is not updated, RD=0, test_value=0.
- Reset asserted mid-sweep: restart from index 0.
- Word index = A[AW+1:2]. Byte lane = A[1:0].
- Fault condition (evaluated only when en=1 and busy=0), any of:
  - A[31:AW+2] ≠ 0 (out of range);
  - size=01 and A[0]=1;
  - size=10 and A[1:0]≠0;
  - size=11.
- On a faulting access: store suppressed, RD=0.
- Stores (en=1, WE=1, busy=0, no fault) write on the posedge:
  - byte: WD[7:0] to lane A[1:0];
  - half: WD[15:0] to lanes {A[1],0} and {A[1],1};
  - word: all 32 bits.
  - Untouched lanes keep their value.
- Loads (en=1, WE=0, busy=0, no fault): RD is combinational in the same cycle.
  - Byte: selected lane, extended from bit 7 per sign_ext.
  - Half: selected half, extended from bit 15 per sign_ext.
  - Word: full word; sign_ext ignored.
- en=0: RD=0, no write, no fault.
- A load in the same cycle as a store to the same word returns the old contents; the new data is visible the next cycle.
- Fault capture on posedge:
  - If a fault condition exists and fault=0: set fault=1 and latch fault_addr=A.
  - If fault=1: later faults do not overwrite fault_addr.
  - fault_clr=1 clears fault and fault_addr to 0.
  - If fault_clr and a new fault occur in the same cycle, the new fault wins: fault=1, fault_addr=A.
- test_value = mem[0] combinationally once busy=0.

Test Plan:
- Release rst at DEPTH=256 -> busy high for exactly 256 edges; RD=0 and test_value=0 throughout; a store of 0xDEADBEEF to A=0x0 with en=1 during busy is ignored (test_value=0 after busy drops).
- sw 0x12345678 @0x10; then lb sign_ext=1 @0x11 -> RD=0x00000056; lh @0x12 -> 0x00001234; lw @0x10 -> 0x12345678.
- sb WD=0x000000FF @0x13; then lb sign_ext=1 @0x13 -> 0xFFFFFFFF; lb sign_ext=0 -> 0x000000FF; lw @0x10 -> 0xFF345678.
- sh @0x21 -> fault=1, fault_addr=0x21, word 0x20 unchanged. Then sw @0x400 (out of range) -> fault_addr stays 0x21. fault_clr with no fault -> fault=0, fault_addr=0. fault_clr together with size=11 @0x8 -> fault=1, fault_addr=0x8.
- sw 0xA5A5A5A5 @0x0 -> test_value=0xA5A5A5A5. Assert rst at sweep index 100 of a second sweep -> busy stays high and 256 further edges are required after release; test_value=0 afterwards.
- Same-cycle store 0x11111111 and load @0x30 (old value 0) -> RD=0 that cycle, 0x11111111 the next cycle.
